// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the starship monster array: top-state encoding and width helpers.
package nexys_starship_pkg;

    // One-hot top-state encodings
    localparam int unsigned TopStateW = 3;
    localparam logic [TopStateW-1:0] IdleOh = 3'b001;
    localparam logic [TopStateW-1:0] PlayOh = 3'b010;
    localparam logic [TopStateW-1:0] OverOh = 3'b100;

    typedef enum logic [TopStateW-1:0] {
        StIdle = IdleOh,
        StPlay = PlayOh,
        StOver = OverOh
    } top_state_e;

    // Bits needed to encode n distinct values, never less than one
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/nexys_starship_monster_chan.sv
// One monster terminal: EMPTY/FULL occupancy with a spawn-delay counter and an expiry counter.
module nexys_starship_monster_chan #(
    parameter int unsigned TIMER_W     = 8,
    parameter int unsigned TIMEOUT     = 12,
    parameter int unsigned SPAWN_DELAY = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,      // channel advances only while the game stays in PLAY
    input  logic hold_i,     // when not running, keep occupancy (game over) instead of clearing
    input  logic tick_i,
    input  logic kill_i,
    input  logic spawn_i,
    output logic full_o,
    output logic eligible_o,
    output logic expire_o
);

    localparam logic [TIMER_W-1:0] TimeoutC = TIMER_W'(TIMEOUT);
    localparam logic [TIMER_W-1:0] DelayC   = TIMER_W'(SPAWN_DELAY);

    logic               full_q, full_d;
    logic [TIMER_W-1:0] dly_q, dly_d;
    logic [TIMER_W-1:0] exp_q, exp_d;

    // Occupancy and counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            dly_q  <= '0;
            exp_q  <= '0;
        end else begin
            full_q <= full_d;
            dly_q  <= dly_d;
            exp_q  <= exp_d;
        end
    end

    // Next-state: kill beats everything, counters saturate at their terminal values
    always_comb begin
        full_d = full_q;
        dly_d  = dly_q;
        exp_d  = exp_q;
        if (!run_i) begin
            full_d = hold_i ? full_q : 1'b0;
            dly_d  = '0;
            exp_d  = '0;
        end else if (full_q) begin
            if (kill_i) begin
                full_d = 1'b0;
                dly_d  = '0;
                exp_d  = '0;
            end else if (tick_i && (exp_q != TimeoutC)) begin
                exp_d = exp_q + TIMER_W'(1);
            end
        end else begin
            if (spawn_i) begin
                full_d = 1'b1;
                dly_d  = '0;
                exp_d  = '0;
            end else if (tick_i && (dly_q != DelayC)) begin
                dly_d = dly_q + TIMER_W'(1);
            end
        end
    end

    // Status outputs; delay never exceeds DelayC, so equality means "waited long enough"
    always_comb begin
        full_o     = full_q;
        eligible_o = !full_q && (dly_q == DelayC);
        expire_o   = full_q && (exp_q == TimeoutC) && !kill_i;
    end

endmodule

// File: rtl/nexys_starship_monster_array.sv
// Monster terminal array: top IDLE/PLAY/OVER FSM, lowest-index spawn arbitration,
// expiry detection and occupancy count around NUM_TERM channel instances.
module nexys_starship_monster_array
    import nexys_starship_pkg::*;
#(
    parameter int unsigned NUM_TERM    = 4,
    parameter int unsigned TIMER_W     = 8,
    parameter int unsigned TIMEOUT     = 12,
    parameter int unsigned SPAWN_DELAY = 1,
    parameter int unsigned MAX_ACTIVE  = 2
) (
    input  logic                                 Clk,
    input  logic                                 Reset_n,
    input  logic                                 timer_tick,
    input  logic                                 play_flag,
    input  logic                                 restart,
    input  logic [NUM_TERM-1:0]                  random,
    input  logic [NUM_TERM-1:0]                  kill,
    output logic [NUM_TERM-1:0]                  monster,
    output logic [cnt_width(NUM_TERM+1)-1:0]     active_cnt,
    output logic                                 gameover,
    output logic [cnt_width(NUM_TERM)-1:0]       over_idx,
    output logic                                 q_Idle,
    output logic                                 q_Play,
    output logic                                 q_Over
);

    localparam int unsigned CntW = cnt_width(NUM_TERM + 1);
    localparam int unsigned IdxW = cnt_width(NUM_TERM);

    top_state_e          state_q, state_d;
    logic [CntW-1:0]     active_cnt_q, active_cnt_d;
    logic [IdxW-1:0]     over_idx_q, over_idx_d;
    logic [CntW-1:0]     live_cnt;
    logic [NUM_TERM-1:0] full, eligible, expire, grant;
    logic                any_expire, grant_found;
    logic [IdxW-1:0]     exp_idx;
    logic                run, hold;

    // Channel instances
    for (genvar g = 0; g < NUM_TERM; g++) begin : g_chan
        nexys_starship_monster_chan #(
            .TIMER_W     (TIMER_W),
            .TIMEOUT     (TIMEOUT),
            .SPAWN_DELAY (SPAWN_DELAY)
        ) u_chan (
            .clk_i      (Clk),
            .rst_ni     (Reset_n),
            .run_i      (run),
            .hold_i     (hold),
            .tick_i     (timer_tick),
            .kill_i     (kill[g]),
            .spawn_i    (grant[g]),
            .full_o     (full[g]),
            .eligible_o (eligible[g]),
            .expire_o   (expire[g])
        );
    end

    // Top state, registered occupancy count and latched expiry index
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= StIdle;
            active_cnt_q <= '0;
            over_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            active_cnt_q <= active_cnt_d;
            over_idx_q   <= over_idx_d;
        end
    end

    // Top next-state; illegal encodings fall back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (play_flag)  state_d = StPlay;
            StPlay:  if (any_expire) state_d = StOver;
            StOver:  if (restart)    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Channels run only while PLAY persists, so the cycle that leaves PLAY already clears counters
    always_comb begin
        run  = (state_q == StPlay) && (state_d == StPlay);
        hold = (state_d == StOver);
    end

    // Live population count and lowest expiring index
    always_comb begin
        live_cnt   = '0;
        any_expire = 1'b0;
        exp_idx    = '0;
        for (int unsigned i = 0; i < NUM_TERM; i++) begin
            live_cnt = live_cnt + CntW'(full[i]);
            if (expire[i] && !any_expire) begin
                any_expire = 1'b1;
                exp_idx    = IdxW'(i);
            end
        end
    end

    // Spawn arbitration: cap uses the live count so back-to-back spawns cannot overshoot
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        if (run && (live_cnt < CntW'(MAX_ACTIVE))) begin
            for (int unsigned i = 0; i < NUM_TERM; i++) begin
                if (!grant_found && eligible[i] && random[i] && !kill[i]) begin
                    grant[i]    = 1'b1;
                    grant_found = 1'b1;
                end
            end
        end
    end

    // Registered count trails monster by one cycle; over_idx latches on entering OVER
    always_comb begin
        active_cnt_d = live_cnt;
        over_idx_d   = over_idx_q;
        if ((state_q == StPlay) && any_expire) begin
            over_idx_d = exp_idx;
        end
    end

    // Output decode
    always_comb begin
        monster    = full;
        active_cnt = active_cnt_q;
        over_idx   = over_idx_q;
        q_Idle     = (state_q == StIdle);
        q_Play     = (state_q == StPlay);
        q_Over     = (state_q == StOver);
        gameover   = (state_q == StOver);
    end

endmodule

// File: tb/tb_nexys_starship_monster_array.sv
// Directed bench for the monster array: default 4-channel instance plus a 1-channel instance.
module tb_nexys_starship_monster_array;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       timer_tick, play_flag, restart;
    logic [3:0] random, kill;
    logic [3:0] monster;
    logic [2:0] active_cnt;
    logic [1:0] over_idx;
    logic       gameover, q_idle, q_play, q_over;

    logic       b_play, b_restart, b_random, b_kill;
    logic       b_monster, b_active, b_over_idx, b_gameover, b_q_idle, b_q_play, b_q_over;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nexys_starship_monster_array u_dut (
        .Clk        (clk),
        .Reset_n    (rst_n),
        .timer_tick (timer_tick),
        .play_flag  (play_flag),
        .restart    (restart),
        .random     (random),
        .kill       (kill),
        .monster    (monster),
        .active_cnt (active_cnt),
        .gameover   (gameover),
        .over_idx   (over_idx),
        .q_Idle     (q_idle),
        .q_Play     (q_play),
        .q_Over     (q_over)
    );

    nexys_starship_monster_array #(
        .NUM_TERM    (1),
        .SPAWN_DELAY (0),
        .MAX_ACTIVE  (1)
    ) u_dut1 (
        .Clk        (clk),
        .Reset_n    (rst_n),
        .timer_tick (timer_tick),
        .play_flag  (b_play),
        .restart    (b_restart),
        .random     (b_random),
        .kill       (b_kill),
        .monster    (b_monster),
        .active_cnt (b_active),
        .gameover   (b_gameover),
        .over_idx   (b_over_idx),
        .q_Idle     (b_q_idle),
        .q_Play     (b_q_play),
        .q_Over     (b_q_over)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        timer_tick = 1'b1;
        step();
        timer_tick = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; timer_tick = 1'b0; play_flag = 1'b0; restart = 1'b0;
        random = 4'b0; kill = 4'b0;
        b_play = 1'b0; b_restart = 1'b0; b_random = 1'b0; b_kill = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q_idle", q_idle, 1);
        chk("rst_q_play", q_play, 0);
        chk("rst_q_over", q_over, 0);
        chk("rst_monster", monster, 0);
        chk("rst_active", active_cnt, 0);
        chk("rst_gameover", gameover, 0);
        chk("rst_over_idx", over_idx, 0);
        rst_n = 1'b1;
        step();

        // Spawn order and cap
        random = 4'b0110; play_flag = 1'b1;
        step();
        play_flag = 1'b0;
        chk("play_entry", q_play, 1);
        chk("play_entry_mon", monster, 4'b0000);
        tick();
        chk("delay_wait", monster, 4'b0000);
        step();
        chk("spawn_first", monster, 4'b0010);
        chk("cnt_lag", active_cnt, 0);
        step();
        chk("spawn_second", monster, 4'b0110);
        chk("cnt_one", active_cnt, 1);
        random = 4'b1111;
        repeat (3) step();
        chk("cap_monster", monster, 4'b0110);
        chk("cap_count", active_cnt, 2);

        // Expiry of channels 1 and 2 together -> lowest index 1
        repeat (11) tick();
        chk("tick11_no_over", gameover, 0);
        tick();
        chk("tick12_still_play", q_play, 1);
        step();
        chk("over_gameover", gameover, 1);
        chk("over_q_over", q_over, 1);
        chk("over_idx_1", over_idx, 1);
        chk("over_hold_mon", monster, 4'b0110);
        random = 4'b0; restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_idle", q_idle, 1);
        chk("restart_mon", monster, 0);
        step();
        chk("restart_cnt", active_cnt, 0);

        // Kill on the 12th tick
        random = 4'b0010; play_flag = 1'b1;
        step();
        play_flag = 1'b0;
        tick();
        step();
        chk("c_spawn", monster, 4'b0010);
        repeat (11) tick();
        timer_tick = 1'b1; kill = 4'b0010;
        step();
        timer_tick = 1'b0; kill = 4'b0;
        chk("kill12_mon", monster, 0);
        chk("kill12_gameover", gameover, 0);
        chk("kill12_cnt_lag", active_cnt, 1);
        step();
        chk("kill12_cnt_dec", active_cnt, 0);

        // Kill in the same cycle the expiry is raised
        tick();
        step();
        chk("respawn", monster, 4'b0010);
        random = 4'b0;
        repeat (12) tick();
        kill = 4'b0010;
        step();
        kill = 4'b0;
        chk("kill_vs_expire_go", gameover, 0);
        chk("kill_vs_expire_play", q_play, 1);
        chk("kill_vs_expire_mon", monster, 0);

        // Channels 0 and 3 expire together
        random = 4'b1001;
        step();
        step();
        chk("ch03_spawned", monster, 4'b1001);
        random = 4'b0;
        repeat (12) tick();
        step();
        chk("ch03_over", gameover, 1);
        chk("ch03_idx", over_idx, 0);
        chk("ch03_hold", monster, 4'b1001);
        restart = 1'b1;
        step();
        restart = 1'b0;

        // Kill on a selected empty channel passes spawn along; then mid-game reset
        random = 4'b0110; play_flag = 1'b1;
        step();
        play_flag = 1'b0;
        tick();
        kill = 4'b0010;
        step();
        kill = 4'b0;
        chk("kill_pass", monster, 4'b0100);
        step();
        chk("two_monsters", monster, 4'b0110);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_mon", monster, 0);
        chk("midrst_cnt", active_cnt, 0);
        chk("midrst_idle", q_idle, 1);
        chk("midrst_play", q_play, 0);
        chk("midrst_over_idx", over_idx, 0);
        #2;
        rst_n = 1'b1;
        random = 4'b1111;
        repeat (4) tick();
        chk("postrst_no_spawn", monster, 0);
        chk("postrst_idle", q_idle, 1);
        play_flag = 1'b1;
        step();
        play_flag = 1'b0;
        chk("replay", q_play, 1);
        tick();
        step();
        chk("replay_spawn", monster, 4'b0001);

        // Single-channel instance, zero spawn delay
        b_play = 1'b1;
        step();
        b_play = 1'b0;
        chk("b_play", b_q_play, 1);
        b_random = 1'b1;
        step();
        chk("b_spawn", b_monster, 1);
        b_kill = 1'b1;
        step();
        b_kill = 1'b0;
        chk("b_kill", b_monster, 0);
        step();
        chk("b_respawn", b_monster, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
